// File: rtl/esc_pkg.sv
// Shared types and constants for the ESC update sequencer.
package esc_pkg;

    localparam int SPD_W = 11;
    localparam logic [SPD_W-1:0] ZERO_SPD = 11'h000;

    typedef enum logic [1:0] {
        OFF,
        ARM,
        RUN
    } esc_state_e;

endpackage

// File: rtl/esc_if.sv
// Speed request/command bundle between the flight controller and sequencer.
interface esc_if;
    import esc_pkg::*;

    logic [SPD_W-1:0] frnt_req;
    logic [SPD_W-1:0] bck_req;
    logic [SPD_W-1:0] lft_req;
    logic [SPD_W-1:0] rght_req;
    logic [SPD_W-1:0] frnt_spd;
    logic [SPD_W-1:0] bck_spd;
    logic [SPD_W-1:0] lft_spd;
    logic [SPD_W-1:0] rght_spd;
    logic             wrt;
    logic             armed;

    modport master (
        output frnt_req, bck_req, lft_req, rght_req,
        input  frnt_spd, bck_spd, lft_spd, rght_spd,
        input  wrt, armed
    );

    modport slave (
        input  frnt_req, bck_req, lft_req, rght_req,
        output frnt_spd, bck_spd, lft_spd, rght_spd,
        output wrt, armed
    );

endinterface

// File: rtl/esc_slew.sv
// One motor channel: rate-limited rise, unrestricted fall, speed register.
module esc_slew
    import esc_pkg::*;
#(
    parameter logic [SPD_W-1:0] SLEW = 11'd16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [SPD_W-1:0] req_i,
    output logic [SPD_W-1:0] spd_o
);

    logic [SPD_W-1:0] spd_q;
    logic [SPD_W-1:0] spd_d;
    logic [SPD_W:0]   diff;
    logic [SPD_W-1:0] step;

    // step never exceeds req-spd, so spd+step stays <= req and cannot wrap
    always_comb begin
        diff = {1'b0, req_i} - {1'b0, spd_q};
        step = (diff > {1'b0, SLEW}) ? SLEW : diff[SPD_W-1:0];
        spd_d = spd_q;
        if (load_i) begin
            spd_d = (req_i > spd_q) ? spd_q + step : req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            spd_q <= ZERO_SPD;
        end else begin
            spd_q <= spd_d;
        end
    end

    assign spd_o = spd_q;

endmodule

// File: rtl/esc_sequencer.sv
// Frame timing, arming FSM and kill handling for four ESC channels.
module esc_sequencer
    import esc_pkg::*;
#(
    parameter int               FRAME_CYCLES = 20000,
    parameter int               ARM_FRAMES   = 50,
    parameter logic [SPD_W-1:0] SLEW         = 11'd16
) (
    input  logic clk,
    input  logic rst,
    input  logic motors_off,
    esc_if.slave bus
);

    localparam int CW = $clog2(FRAME_CYCLES);
    localparam int AW = $clog2(ARM_FRAMES + 1);

    esc_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    arm_q;
    logic [AW-1:0]    arm_nxt;
    logic             wrt_q;
    logic             armed_q;
    logic             tc;
    logic             kill;
    logic             load;
    logic [SPD_W-1:0] req_a [4];
    logic [SPD_W-1:0] spd_a [4];

    assign tc      = (cnt_q == CW'(FRAME_CYCLES - 1));
    assign kill    = motors_off && (state_q != OFF);
    assign load    = tc && (state_q == RUN) && !kill;
    assign arm_nxt = arm_q + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            arm_q   <= '0;
            wrt_q   <= 1'b0;
            armed_q <= 1'b0;
        end else if (kill) begin
            // kill wins over a coincident boundary: one pulse, zero speeds
            state_q <= OFF;
            cnt_q   <= '0;
            wrt_q   <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            wrt_q <= tc;
            cnt_q <= tc ? '0 : cnt_q + CW'(1);
            if (tc) begin
                unique case (state_q)
                    OFF: begin
                        if (!motors_off) begin
                            state_q <= ARM;
                            arm_q   <= '0;
                        end
                    end
                    ARM: begin
                        arm_q <= arm_nxt;
                        if (arm_nxt == AW'(ARM_FRAMES)) begin
                            state_q <= RUN;
                            armed_q <= 1'b1;
                        end
                    end
                    RUN: ;
                    default: state_q <= OFF;
                endcase
            end
        end
    end

    assign req_a[0] = bus.frnt_req;
    assign req_a[1] = bus.bck_req;
    assign req_a[2] = bus.lft_req;
    assign req_a[3] = bus.rght_req;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        esc_slew #(.SLEW(SLEW)) u_slew (
            .clk_i  (clk),
            .rst_i  (rst),
            .clr_i  (kill),
            .load_i (load),
            .req_i  (req_a[g]),
            .spd_o  (spd_a[g])
        );
    end

    assign bus.frnt_spd = spd_a[0];
    assign bus.bck_spd  = spd_a[1];
    assign bus.lft_spd  = spd_a[2];
    assign bus.rght_spd = spd_a[3];
    assign bus.wrt      = wrt_q;
    assign bus.armed    = armed_q;

endmodule

// File: tb/tb_esc_sequencer.sv
// Directed bench for esc_sequencer with short frames and three arm frames.
module tb_esc_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic motors_off;
    int   ncmp  = 0;
    int   nfail = 0;
    int   c;

    esc_if bus ();

    esc_sequencer #(
        .FRAME_CYCLES (100),
        .ARM_FRAMES   (3),
        .SLEW         (11'd16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .motors_off (motors_off),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.wrt && n < 300);
    endtask

    task automatic set_req(input int f, input int b, input int l,
                           input int r);
        bus.frnt_req = 11'(f);
        bus.bck_req  = 11'(b);
        bus.lft_req  = 11'(l);
        bus.rght_req = 11'(r);
    endtask

    task automatic chk_spd(input string tag, input int f, input int b,
                           input int l, input int r);
        chk({tag, "_frnt"}, 32'(bus.frnt_spd), f);
        chk({tag, "_bck"},  32'(bus.bck_spd),  b);
        chk({tag, "_lft"},  32'(bus.lft_spd),  l);
        chk({tag, "_rght"}, 32'(bus.rght_spd), r);
    endtask

    task automatic frame(input string tag, input int f, input int b,
                         input int l, input int r, input int arm,
                         input int gap);
        int n;
        wait_wrt(n);
        chk({tag, "_gap"}, n, gap);
        chk_spd(tag, f, b, l, r);
        chk({tag, "_armed"}, 32'(bus.armed), arm);
        tick();
        chk({tag, "_wrt_lo"}, 32'(bus.wrt), 0);
        chk_spd({tag, "_hold"}, f, b, l, r);
    endtask

    initial begin
        int ramp [8] = '{16, 32, 48, 64, 80, 96, 100, 100};
        int e;
        rst        = 1'b1;
        motors_off = 1'b1;
        set_req(0, 0, 0, 0);
        tick();
        tick();
        chk("rst_wrt", 32'(bus.wrt), 0);
        chk("rst_armed", 32'(bus.armed), 0);
        chk_spd("rst", 0, 0, 0, 0);

        rst        = 1'b0;
        motors_off = 1'b0;
        set_req(100, 100, 100, 100);
        frame("arm0", 0, 0, 0, 0, 0, 100);
        frame("arm1", 0, 0, 0, 0, 0, 99);
        frame("arm2", 0, 0, 0, 0, 0, 99);
        frame("arm3", 0, 0, 0, 0, 1, 99);
        foreach (ramp[i]) begin
            frame($sformatf("ramp%0d", i), ramp[i], ramp[i], ramp[i],
                  ramp[i], 1, 99);
        end

        set_req(20, 10, 30, 0);
        frame("dec", 20, 10, 30, 0, 1, 99);

        set_req(100, 100, 100, 100);
        repeat (36) tick();
        motors_off = 1'b1;
        tick();
        chk("kill_wrt", 32'(bus.wrt), 1);
        chk("kill_armed", 32'(bus.armed), 0);
        chk_spd("kill", 0, 0, 0, 0);
        tick();
        chk("kill_wrt_lo", 32'(bus.wrt), 0);
        wait_wrt(c);
        chk("off_gap", c, 99);
        chk_spd("off", 0, 0, 0, 0);
        chk("off_armed", 32'(bus.armed), 0);
        tick();
        chk("off_wrt_lo", 32'(bus.wrt), 0);

        motors_off = 1'b0;
        frame("rearm0", 0, 0, 0, 0, 0, 99);
        frame("rearm1", 0, 0, 0, 0, 0, 99);
        frame("rearm2", 0, 0, 0, 0, 0, 99);
        frame("rearm3", 0, 0, 0, 0, 1, 99);

        repeat (98) tick();
        motors_off = 1'b1;
        tick();
        chk("sim_wrt", 32'(bus.wrt), 1);
        chk("sim_armed", 32'(bus.armed), 0);
        chk_spd("sim", 0, 0, 0, 0);
        tick();
        chk("sim_wrt_lo", 32'(bus.wrt), 0);
        motors_off = 1'b0;
        frame("sarm0", 0, 0, 0, 0, 0, 99);
        frame("sarm1", 0, 0, 0, 0, 0, 99);
        frame("sarm2", 0, 0, 0, 0, 0, 99);
        frame("sarm3", 0, 0, 0, 0, 1, 99);

        set_req(2040, 2040, 2040, 2040);
        for (int k = 1; k <= 128; k++) begin
            e = (16 * k > 2040) ? 2040 : 16 * k;
            frame($sformatf("sat%0d", k), e, e, e, e, 1, 99);
        end
        set_req(2047, 2047, 2047, 2047);
        frame("top", 2047, 2047, 2047, 2047, 1, 99);
        frame("top_hold", 2047, 2047, 2047, 2047, 1, 99);

        set_req(500, 500, 500, 500);
        frame("to500", 500, 500, 500, 500, 1, 99);
        repeat (10) tick();
        rst        = 1'b1;
        motors_off = 1'b1;
        tick();
        chk("rrst_wrt", 32'(bus.wrt), 0);
        chk("rrst_armed", 32'(bus.armed), 0);
        chk_spd("rrst", 0, 0, 0, 0);
        rst        = 1'b0;
        motors_off = 1'b0;
        frame("rarm0", 0, 0, 0, 0, 0, 100);
        frame("rarm1", 0, 0, 0, 0, 0, 99);
        frame("rarm2", 0, 0, 0, 0, 0, 99);
        frame("rarm3", 0, 0, 0, 0, 1, 99);
        frame("rrun", 16, 16, 16, 16, 1, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
